// File: rtl/seq_stepper.sv
// Programmable LENGTH-position code stepper with forward/reverse/hold/jump and wrap/load-error pulses.
// Optional build macro SEQ_STEPPER_GRAY_EN switches `result` to Gray-coded output.
module seq_stepper #(
  parameter int WIDTH  = 2,
  parameter int LENGTH = 4,
  parameter int START  = 3
) (
  input  logic             clockPulse,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_index,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] index,
  output logic             wrap,
  output logic             load_err
);

  // Parameter legality is fixed at build time; a bad combination must not produce a netlist.
  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $fatal(1, "seq_stepper: WIDTH must be 1..30");
  end
  if (LENGTH < 2 || longint'(LENGTH) > (longint'(1) << WIDTH)) begin : g_bad_length
    $fatal(1, "seq_stepper: LENGTH must be 2..2**WIDTH");
  end
  if (START < 0 || longint'(START) >= (longint'(1) << WIDTH)) begin : g_bad_start
    $fatal(1, "seq_stepper: START must be 0..2**WIDTH-1");
  end

  localparam logic [WIDTH:0]   LEN_W   = (WIDTH+1)'(LENGTH);
  localparam logic [WIDTH:0]   START_W = (WIDTH+1)'(START);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LENGTH - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(0);

  function automatic logic [WIDTH-1:0] code_of(input logic [WIDTH-1:0] idx);
    logic [WIDTH:0] sum;
    sum = {1'b0, idx} + START_W;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
`ifdef SEQ_STEPPER_GRAY_EN
    return b ^ (b >> 1'b1);
`else
    return b;
`endif
  endfunction

  localparam logic [WIDTH-1:0] RESET_CODE = encode(code_of(ZERO_W));

  logic [WIDTH-1:0] index_r;
  logic [WIDTH-1:0] result_r;
  logic             wrap_r;
  logic             load_err_r;

  logic [WIDTH-1:0] index_next_s;
  logic             wrap_next_s;
  logic             load_err_next_s;
  logic             load_ok_s;

  assign load_ok_s = ({1'b0, load_index} < LEN_W);

  // Next position and pulse flags: load beats enable beats hold.
  always_comb begin
    index_next_s    = index_r;
    wrap_next_s     = 1'b0;
    load_err_next_s = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        index_next_s = load_index;
      end else begin
        load_err_next_s = 1'b1;
      end
    end else if (enable) begin
      if (dir == 1'b0) begin
        if (index_r == LAST_W) begin
          index_next_s = ZERO_W;
          wrap_next_s  = 1'b1;
        end else begin
          index_next_s = index_r + ONE_W;
        end
      end else begin
        if (index_r == ZERO_W) begin
          index_next_s = LAST_W;
          wrap_next_s  = 1'b1;
        end else begin
          index_next_s = index_r - ONE_W;
        end
      end
    end else begin
      index_next_s = index_r;
    end
  end

  // Output registers; the code is derived from the next index so result and index move together.
  always_ff @(posedge clockPulse or posedge reset) begin
    if (reset) begin
      index_r    <= ZERO_W;
      result_r   <= RESET_CODE;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      index_r    <= index_next_s;
      result_r   <= encode(code_of(index_next_s));
      wrap_r     <= wrap_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  assign index    = index_r;
  assign result   = result_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

endmodule
